// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file slice.
// No logic; constants, clear-sequencer state encoding and helpers only.
// No flow control; consumers apply their own.
package gpr_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register index
  localparam int REG_ZERO = 0;

  // Clear sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/gpr_clear_seq.sv
// Clear sequencer: walks idx 1..NREGS-1, one register zeroed per cycle.
// Sweep takes NREGS-1 cycles after the request edge; clr_busy is registered.
// No backpressure; clr_req is ignored while a sweep is running.
module gpr_clear_seq
  import gpr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State and index registers; reset aborts any sweep in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: start on request, step idx, return to IDLE after the last register
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = IDX_FIRST;
        end
      end
      ST_SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign clr_busy = (state_q == ST_SWEEP);
  assign clr_en   = (state_q == ST_SWEEP);
  assign clr_idx  = idx_q;

endmodule

// File: rtl/gpr_mp.sv
// Multi-port GPR file: NRD combinational reads, two write ports, r0 hardwired to zero.
// Reads 0 cycles (optional same-cycle bypass); writes visible next cycle.
// No stall generated; writes during a clear sweep are dropped and flagged via wr_drop.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  wr_drop
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [NREGS];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr0_vld;
  logic              wr1_vld;
  logic              wr0_lose;

  gpr_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  // Writes to r0 are not real writes: never stored, never counted as dropped
  assign wr0_vld  = we0 && (wa0 != ZERO_A);
  assign wr1_vld  = we1 && (wa1 != ZERO_A);
  // Load return beats writeback on an address collision
  assign wr0_lose = wr1_vld && (wa1 == wa0);

  // Storage update: sweep clearing has priority, port writes only when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= clr_busy && (wr0_vld || wr1_vld);
      if (clr_en) begin
        mem_q[clr_idx] <= '0;
      end else begin
        if (wr0_vld && !wr0_lose) begin
          mem_q[wa0] <= wd0;
        end
        if (wr1_vld) begin
          mem_q[wa1] <= wd1;
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux: r0 forced to zero, then bypass of in-flight writes (port 1 first), else storage
    always_comb begin
      rdat = mem_q[ra];
      if (ra == ZERO_A) begin
        rdat = '0;
      end else if ((BYPASS != 0) && !clr_busy) begin
        if (wr1_vld && (wa1 == ra)) begin
          rdat = wd1;
        end else if (wr0_vld && (wa0 == ra)) begin
          rdat = wd0;
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
  end

endmodule

// File: tb/tb_gpr_mp.sv
// Testbench for gpr_mp: table-driven read/write vectors on BYPASS=1 and BYPASS=0
// instances sharing stimulus, plus hand-written reset, clear-sweep and drop sequences.
// Outputs are sampled 1 time unit after inputs settle, away from the posedge.
module tb_gpr_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_b1;
  logic [63:0] rd_b0;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        clr_req;
  logic        busy_b1, busy_b0;
  logic        drop_b1, drop_b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gpr_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) u_b1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_b1),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(busy_b1), .wr_drop(drop_b1)
  );

  gpr_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) u_b0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_b0),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(busy_b0), .wr_drop(drop_b0)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] b1_0;  // expected same-cycle read, bypass instance
    logic [31:0] b1_1;
    logic [31:0] b0_0;  // expected same-cycle read, no-bypass instance
    logic [31:0] b0_1;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    clr_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             we0 wa0 wd0           we1 wa1 wd1       ra0 ra1 b1_0          b1_1          b0_0          b0_1
    tv[0] = '{1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 5'd3, 32'h0000_5555, 5'd3, 5'd0, 32'h0000_5555, 32'h0, 32'h0, 32'h0};
    tv[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1, 32'h0000_5555, 32'h0, 32'h0000_5555, 32'h0};
    tv[2] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 32'h0, 32'h0000_5555, 32'h0, 32'h0000_5555};
    tv[4] = '{1'b1, 5'd5, 32'h0000_1234, 1'b1, 5'd6, 32'h0000_0066, 5'd5, 5'd6, 32'h0000_1234, 32'h0000_0066, 32'h0, 32'h0};
    tv[5] = '{1'b1, 5'd6, 32'h0000_DEAD, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 32'h0000_DEAD, 32'h0000_1234, 32'h0000_0066, 32'h0000_1234};
    tv[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5, 32'h0000_DEAD, 32'h0000_1234, 32'h0000_DEAD, 32'h0000_1234};
    tv[7] = '{1'b1, 5'd7, 32'h0000_0042, 1'b1, 5'd5, 32'h0000_BEEF, 5'd5, 5'd7, 32'h0000_BEEF, 32'h0000_0042, 32'h0000_1234, 32'h0};
    tv[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 32'h0000_0042, 32'h0000_BEEF, 32'h0000_0042, 32'h0000_BEEF};

    // Reset state
    reset = 1'b0;
    idle_inputs();
    set_rd(5'd3, 5'd31);
    #12;
    chk("reset_rd0", rd_b1[31:0], 32'h0);
    chk("reset_rd1", rd_b1[63:32], 32'h0);
    chk("reset_busy", {31'h0, busy_b1}, 32'h0);
    chk("reset_drop", {31'h0, drop_b1}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table: writes, collisions, r0 writes, bypass vs no-bypass reads
    for (int i = 0; i < 9; i++) begin
      we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
      we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
      set_rd(tv[i].ra0, tv[i].ra1);
      #1;
      chk($sformatf("tv%0d_b1_p0", i), rd_b1[31:0], tv[i].b1_0);
      chk($sformatf("tv%0d_b1_p1", i), rd_b1[63:32], tv[i].b1_1);
      chk($sformatf("tv%0d_b0_p0", i), rd_b0[31:0], tv[i].b0_0);
      chk($sformatf("tv%0d_b0_p1", i), rd_b0[63:32], tv[i].b0_1);
      chk($sformatf("tv%0d_drop", i), {31'h0, drop_b1}, 32'h0);
      tick();
      idle_inputs();
    end

    // Reset mid-operation after r5 = 0x1234
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_1234;
    tick();
    idle_inputs();
    set_rd(5'd5, 5'd7);
    #1;
    chk("pre_rst_r5", rd_b1[31:0], 32'h0000_1234);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_r5", rd_b1[31:0], 32'h0);
    chk("mid_rst_r7", rd_b1[63:32], 32'h0);
    chk("mid_rst_busy", {31'h0, busy_b1}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fill r1..r31 with their index
    for (int r = 1; r < 32; r++) begin
      we0 = 1'b1; wa0 = 5'(r); wd0 = 32'(r);
      tick();
    end
    idle_inputs();
    set_rd(5'd1, 5'd31);
    #1;
    chk("fill_r1", rd_b1[31:0], 32'd1);
    chk("fill_r31", rd_b1[63:32], 32'd31);

    // Pulse clr_req: sweep zeroes r1..r31, one per edge
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    chk("sweep_start_busy", {31'h0, busy_b1}, 32'h1);
    chk("sweep_start_r1", rd_b1[31:0], 32'd1);
    for (int k = 1; k < 32; k++) begin
      tick();
      set_rd(5'(k), (k < 31) ? 5'(k + 1) : 5'd0);
      #1;
      chk($sformatf("sweep%0d_rk", k), rd_b1[31:0], 32'h0);
      chk($sformatf("sweep%0d_next", k), rd_b1[63:32], (k < 31) ? 32'(k + 1) : 32'h0);
      chk($sformatf("sweep%0d_busy", k), {31'h0, busy_b1}, (k < 31) ? 32'h1 : 32'h0);
    end
    for (int r = 1; r < 32; r += 2) begin
      set_rd(5'(r), 5'(r + 1));
      #1;
      chk($sformatf("post_sweep_r%0d", r), rd_b1[31:0], 32'h0);
      chk($sformatf("post_sweep_r%0d", r + 1), rd_b1[63:32], 32'h0);
    end

    // Write dropped during sweep, then reset at idx=10
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9;  wd0 = 32'h0000_0099;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'h0000_00BB;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0077;
    set_rd(5'd9, 5'd11);
    #1;
    chk("sweep_nobypass_r9", rd_b1[31:0], 32'h0000_0099);
    tick();
    idle_inputs();
    #1;
    chk("sweep_drop_flag", {31'h0, drop_b1}, 32'h1);
    chk("sweep_drop_r9", rd_b1[31:0], 32'h0000_0099);
    for (int e = 2; e <= 9; e++) begin
      tick();
      if (e == 2) chk("sweep_drop_clears", {31'h0, drop_b1}, 32'h0);
    end
    #1;
    chk("sweep_idx9_r9", rd_b1[31:0], 32'h0);
    chk("sweep_idx9_r11", rd_b1[63:32], 32'h0000_00BB);
    chk("sweep_idx9_busy", {31'h0, busy_b1}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("sweep_rst_busy", {31'h0, busy_b1}, 32'h0);
    chk("sweep_rst_r11", rd_b1[63:32], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0044;
    tick();
    idle_inputs();
    set_rd(5'd4, 5'd11);
    #1;
    chk("after_rst_write_r4", rd_b1[31:0], 32'h0000_0044);
    chk("after_rst_busy", {31'h0, busy_b1}, 32'h0);
    chk("after_rst_drop", {31'h0, drop_b1}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
